// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: control unit for the multicycle ARM datapath.
// Contains the main FSM, ALU decoder, condition check and NZCV flag register.
// FETCH, MEMRD and MEMWR wait on MemReady so slow memory stalls the machine.
// Outputs are combinational from the state register plus the instruction fields.
// Optional feature: define CTRL_CMP_EN to decode Funct[4:1]=1010 with S=1 as CMP.
// CMP sets NZCV from a subtract and returns to FETCH without a write-back state.

module multicycle_ctrl_fsm #(
    parameter int         STATE_W     = 4,
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               MemReady,
    input  logic [3:0]         Cond,
    input  logic [1:0]         Op,
    input  logic [5:0]         Funct,
    input  logic [3:0]         Rd,
    input  logic [3:0]         ALUFlags,
    output logic               PCWrite,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               AdrSrc,
    output logic [1:0]         RegSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ImmSrc,
    output logic [1:0]         ALUControl,
    output logic [STATE_W-1:0] State
);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = STATE_W'(0),
        S_DECODE = STATE_W'(1),
        S_MEMADR = STATE_W'(2),
        S_MEMRD  = STATE_W'(3),
        S_MEMWB  = STATE_W'(4),
        S_MEMWR  = STATE_W'(5),
        S_EXECR  = STATE_W'(6),
        S_EXECI  = STATE_W'(7),
        S_ALUWB  = STATE_W'(8),
        S_BRANCH = STATE_W'(9)
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    state_t     r_state;
    logic [3:0] r_flags;   // {N, Z, C, V}

    logic [1:0] w_alu_ctl;
    logic       w_dp_ok;     // supported data-processing command that writes Rd
    logic       w_cmp;       // compare: flags only, no write-back
    logic       w_cv_upd;    // command produces meaningful C and V
    logic       w_condex;
    logic       w_exec;
    logic       w_flag_upd;
    logic       w_regw;
    logic       w_memw;
    logic       w_branch;
    logic       w_irwrite;
    logic       w_fetch_adv;
    logic       w_adrsrc;
    logic [1:0] w_alusrca;
    logic [1:0] w_alusrcb;
    logic [1:0] w_resultsrc;
    logic [1:0] w_aluctl_out;

    // ALU decoder: map the data-processing command to an ALU operation
    always_comb begin
        w_alu_ctl = ALU_ADD;
        w_dp_ok   = 1'b0;
        w_cmp     = 1'b0;
        w_cv_upd  = 1'b0;
        case (Funct[4:1])
            4'b0100: begin w_alu_ctl = ALU_ADD; w_dp_ok = 1'b1; w_cv_upd = 1'b1; end
            4'b0010: begin w_alu_ctl = ALU_SUB; w_dp_ok = 1'b1; w_cv_upd = 1'b1; end
            4'b0000: begin w_alu_ctl = ALU_AND; w_dp_ok = 1'b1; end
            4'b1100: begin w_alu_ctl = ALU_ORR; w_dp_ok = 1'b1; end
`ifdef CTRL_CMP_EN
            4'b1010: begin
                if (Funct[0]) begin
                    w_alu_ctl = ALU_SUB;
                    w_cmp     = 1'b1;
                    w_cv_upd  = 1'b1;
                end
            end
`endif
            default: ;  // unsupported: ADD, no write, no flag update
        endcase
    end

    // Condition check against the stored flags
    always_comb begin
        w_condex = 1'b0;
        case (Cond)
            4'b0000: w_condex = r_flags[2];                                  // EQ
            4'b0001: w_condex = ~r_flags[2];                                 // NE
            4'b0010: w_condex = r_flags[1];                                  // CS
            4'b0011: w_condex = ~r_flags[1];                                 // CC
            4'b0100: w_condex = r_flags[3];                                  // MI
            4'b0101: w_condex = ~r_flags[3];                                 // PL
            4'b0110: w_condex = r_flags[0];                                  // VS
            4'b0111: w_condex = ~r_flags[0];                                 // VC
            4'b1000: w_condex = r_flags[1] & ~r_flags[2];                    // HI
            4'b1001: w_condex = ~r_flags[1] | r_flags[2];                    // LS
            4'b1010: w_condex = (r_flags[3] == r_flags[0]);                  // GE
            4'b1011: w_condex = (r_flags[3] != r_flags[0]);                  // LT
            4'b1100: w_condex = ~r_flags[2] & (r_flags[3] == r_flags[0]);    // GT
            4'b1101: w_condex = r_flags[2] | (r_flags[3] != r_flags[0]);     // LE
            4'b1110: w_condex = 1'b1;                                        // AL
            default: w_condex = 1'b0;                                        // never
        endcase
    end

    assign w_exec     = (r_state == S_EXECR) || (r_state == S_EXECI);
    assign w_flag_upd = w_exec & Funct[0] & w_condex & (w_dp_ok | w_cmp);

    // Per-state datapath controls and raw (ungated) write requests
    always_comb begin
        w_regw       = 1'b0;
        w_memw       = 1'b0;
        w_branch     = 1'b0;
        w_irwrite    = 1'b0;
        w_fetch_adv  = 1'b0;
        w_adrsrc     = 1'b0;
        w_alusrca    = 2'b00;
        w_alusrcb    = 2'b00;
        w_resultsrc  = 2'b00;
        w_aluctl_out = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                w_alusrca   = 2'b01;
                w_alusrcb   = 2'b10;
                w_resultsrc = 2'b10;
                if (MemReady) begin
                    w_irwrite   = 1'b1;
                    w_fetch_adv = 1'b1;
                end
            end
            S_DECODE: begin
                w_alusrca   = 2'b01;
                w_alusrcb   = 2'b10;
                w_resultsrc = 2'b10;
            end
            S_MEMADR: w_alusrcb = 2'b01;
            S_MEMRD:  w_adrsrc  = 1'b1;
            S_MEMWB: begin
                w_resultsrc = 2'b01;
                w_regw      = 1'b1;
            end
            S_MEMWR: begin
                w_adrsrc = 1'b1;
                w_memw   = 1'b1;
            end
            S_EXECR: w_aluctl_out = w_alu_ctl;
            S_EXECI: begin
                w_alusrcb    = 2'b01;
                w_aluctl_out = w_alu_ctl;
            end
            S_ALUWB: w_regw = w_dp_ok;
            S_BRANCH: begin
                w_alusrcb   = 2'b01;
                w_resultsrc = 2'b10;
                w_branch    = 1'b1;
            end
            default: ;
        endcase
    end

    // Main FSM: state advance, with stalls on MemReady in memory states
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:  if (MemReady) r_state <= S_DECODE;
                S_DECODE: begin
                    case (Op)
                        2'b00:   r_state <= Funct[5] ? S_EXECI : S_EXECR;
                        2'b01:   r_state <= S_MEMADR;
                        2'b10:   r_state <= S_BRANCH;
                        default: r_state <= S_FETCH;
                    endcase
                end
                S_MEMADR: r_state <= Funct[0] ? S_MEMRD : S_MEMWR;
                S_MEMRD:  if (MemReady) r_state <= S_MEMWB;
                S_MEMWB:  r_state <= S_FETCH;
                S_MEMWR:  if (MemReady) r_state <= S_FETCH;
                S_EXECR,
                S_EXECI:  r_state <= w_cmp ? S_FETCH : S_ALUWB;
                S_ALUWB:  r_state <= S_FETCH;
                S_BRANCH: r_state <= S_FETCH;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    // NZCV register: captured at the end of an S-suffixed EXEC cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flags <= RESET_FLAGS;
        end else if (w_flag_upd) begin
            r_flags[3:2] <= ALUFlags[3:2];
            if (w_cv_upd) r_flags[1:0] <= ALUFlags[1:0];
        end
    end

    assign IRWrite    = w_irwrite;
    assign RegWrite   = w_regw & w_condex;
    assign MemWrite   = w_memw & w_condex;
    assign PCWrite    = w_fetch_adv | ((w_branch | (w_regw & (Rd == 4'hF))) & w_condex);
    assign AdrSrc     = w_adrsrc;
    assign ALUSrcA    = w_alusrca;
    assign ALUSrcB    = w_alusrcb;
    assign ResultSrc  = w_resultsrc;
    assign ALUControl = w_aluctl_out;
    assign RegSrc     = {(Op == 2'b01), (Op == 2'b10)};
    assign ImmSrc     = Op;
    assign State      = r_state;

endmodule
